// File: rtl/maint_req_gen.sv
// Periodic maintenance request generator: refresh timer, ZQ-short and periodic reads.
// Define MAINT_REF_POSTPONE_EN to allow up to 8 postponed refreshes (default: 1).
module maint_req_gen #(
    parameter int unsigned ZQ_REF_RATIO   = 128,
    parameter int unsigned PR_RD_INTERVAL = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ref_en,
    input  logic        zq_en,
    input  logic        pr_rd_en,
    input  logic [27:0] trefi,
    input  logic        autoref_ack,
    input  logic        zq_ack,
    input  logic        periodic_read_lock,
    output logic        autoref_req,
    output logic        zq_req,
    output logic        pr_rd_req,
    output logic [3:0]  ref_pending,
    output logic        ref_overflow
);

`ifdef MAINT_REF_POSTPONE_EN
    localparam logic [3:0] REF_MAX = 4'd8;
`else
    localparam logic [3:0] REF_MAX = 4'd1;
`endif

    localparam logic [16:0] ZQ_RATIO = 17'(ZQ_REF_RATIO);
    localparam logic [19:0] PR_LAST  = 20'(PR_RD_INTERVAL - 1);

    logic [27:0] tmr_q, tmr_d;
    logic        armed_q, armed_d;
    logic        tick;
    logic [27:0] reload;
    logic [3:0]  pend_q, pend_d;
    logic        ovf_q, ovf_d;
    logic [15:0] zq_cnt_q, zq_cnt_d;
    logic        zq_q, zq_d;
    logic        zq_set;
    logic [19:0] pr_cnt_q, pr_cnt_d;
    logic        pr_q, pr_d;

    assign reload = trefi - 28'd1;

    // The first enabled cycle only loads, so the first tick lands trefi+1 cycles in.
    always_comb begin
        tick    = 1'b0;
        tmr_d   = tmr_q;
        armed_d = armed_q;
        if (ref_en && (trefi != 28'd0)) begin
            armed_d = 1'b1;
            if (!armed_q) begin
                tmr_d = reload;
            end else if (tmr_q == 28'd0) begin
                tick  = 1'b1;
                tmr_d = reload;
            end else begin
                tmr_d = tmr_q - 28'd1;
            end
        end else begin
            armed_d = 1'b0;
            tmr_d   = (trefi == 28'd0) ? 28'd0 : reload;
        end
    end

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick && !autoref_ack) begin
            if (pend_q == REF_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 4'd1;
            end
        end else if (!tick && autoref_ack && (pend_q != 4'd0)) begin
            pend_d = pend_q - 4'd1;
        end
    end

    always_comb begin
        zq_cnt_d = zq_cnt_q;
        zq_set   = 1'b0;
        if (!zq_en) begin
            zq_cnt_d = 16'd0;
        end else if (autoref_ack) begin
            if (({1'b0, zq_cnt_q} + 17'd1) == ZQ_RATIO) begin
                zq_cnt_d = 16'd0;
                zq_set   = 1'b1;
            end else begin
                zq_cnt_d = zq_cnt_q + 16'd1;
            end
        end
        zq_d = zq_set | (zq_q & ~zq_ack);
    end

    always_comb begin
        pr_cnt_d = pr_cnt_q;
        pr_d     = pr_q;
        if (!pr_rd_en) begin
            pr_cnt_d = 20'd0;
            pr_d     = 1'b0;
        end else if (pr_q) begin
            if (periodic_read_lock) begin
                pr_d = 1'b0;
            end
        end else if (!periodic_read_lock) begin
            if (pr_cnt_q == PR_LAST) begin
                pr_d     = 1'b1;
                pr_cnt_d = 20'd0;
            end else begin
                pr_cnt_d = pr_cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q    <= 28'd0;
            armed_q  <= 1'b0;
            pend_q   <= 4'd0;
            ovf_q    <= 1'b0;
            zq_cnt_q <= 16'd0;
            zq_q     <= 1'b0;
            pr_cnt_q <= 20'd0;
            pr_q     <= 1'b0;
        end else begin
            tmr_q    <= tmr_d;
            armed_q  <= armed_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            zq_cnt_q <= zq_cnt_d;
            zq_q     <= zq_d;
            pr_cnt_q <= pr_cnt_d;
            pr_q     <= pr_d;
        end
    end

    assign autoref_req  = (pend_q != 4'd0);
    assign zq_req       = zq_q;
    assign pr_rd_req    = pr_q;
    assign ref_pending  = pend_q;
    assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_maint_req_gen.sv
// Bench for maint_req_gen: event-scheduled reference model plus directed timing checks.
module tb_maint_req_gen;

    localparam int ZQR = 4;
    localparam int PRI = 16;
`ifdef MAINT_REF_POSTPONE_EN
    localparam int MAXP = 8;
`else
    localparam int MAXP = 1;
`endif
    localparam int TGT = (MAXP >= 3) ? 3 : 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ref_en = 1'b0;
    logic        zq_en = 1'b0;
    logic        pr_rd_en = 1'b0;
    logic [27:0] trefi = 28'd100;
    logic        autoref_ack = 1'b0;
    logic        zq_ack = 1'b0;
    logic        periodic_read_lock = 1'b0;
    logic        autoref_req, zq_req, pr_rd_req, ref_overflow;
    logic [3:0]  ref_pending;

    int checks = 0;
    int errors = 0;
    bit active = 1'b0;

    maint_req_gen #(.ZQ_REF_RATIO(ZQR), .PR_RD_INTERVAL(PRI)) dut (
        .clk(clk), .rst_n(rst_n), .ref_en(ref_en), .zq_en(zq_en),
        .pr_rd_en(pr_rd_en), .trefi(trefi), .autoref_ack(autoref_ack),
        .zq_ack(zq_ack), .periodic_read_lock(periodic_read_lock),
        .autoref_req(autoref_req), .zq_req(zq_req), .pr_rd_req(pr_rd_req),
        .ref_pending(ref_pending), .ref_overflow(ref_overflow)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: refresh ticks scheduled at absolute cycle numbers
    int m_cyc = 0, m_pend = 0, m_next = 0, m_zqn = 0, m_prn = 0;
    bit m_armed = 0, m_ovf = 0, m_zq = 0, m_pr = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit tk, zset;
        if (!rst_n) begin
            m_cyc = 0; m_pend = 0; m_next = 0; m_zqn = 0; m_prn = 0;
            m_armed = 0; m_ovf = 0; m_zq = 0; m_pr = 0;
        end else begin
            tk = 0;
            zset = 0;
            if (ref_en && trefi != 0) begin
                if (!m_armed) begin
                    m_armed = 1;
                    m_next = m_cyc + int'(trefi);
                end else if (m_cyc == m_next) begin
                    tk = 1;
                    m_next = m_cyc + int'(trefi);
                end
            end else begin
                m_armed = 0;
            end
            if (tk && !autoref_ack) begin
                if (m_pend == MAXP) m_ovf = 1;
                else m_pend++;
            end else if (!tk && autoref_ack && m_pend > 0) begin
                m_pend--;
            end
            if (!zq_en) m_zqn = 0;
            else if (autoref_ack) begin
                m_zqn++;
                if (m_zqn == ZQR) begin
                    m_zqn = 0;
                    zset = 1;
                end
            end
            m_zq = zset ? 1'b1 : (zq_ack ? 1'b0 : m_zq);
            if (!pr_rd_en) begin
                m_prn = 0;
                m_pr = 0;
            end else if (m_pr) begin
                if (periodic_read_lock) m_pr = 0;
            end else if (!periodic_read_lock) begin
                m_prn++;
                if (m_prn == PRI) begin
                    m_pr = 1;
                    m_prn = 0;
                end
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (active) begin
            cmp("m_autoref_req", int'(autoref_req), int'(m_pend != 0));
            cmp("m_ref_pending", int'(ref_pending), m_pend);
            cmp("m_ref_overflow", int'(ref_overflow), int'(m_ovf));
            cmp("m_zq_req", int'(zq_req), int'(m_zq));
            cmp("m_pr_rd_req", int'(pr_rd_req), int'(m_pr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        autoref_ack = 1'b1;
        step();
        autoref_ack = 1'b0;
    endtask

    task automatic wait_inc(output int n);
        int start;
        start = int'(ref_pending);
        n = 0;
        do begin
            step();
            n++;
        end while (int'(ref_pending) <= start && n < 600);
    endtask

    task automatic wait_pr(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!pr_rd_req && n < 600);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ref_en = 1'b0;
        zq_en = 1'b0;
        pr_rd_en = 1'b0;
        autoref_ack = 1'b0;
        zq_ack = 1'b0;
        periodic_read_lock = 1'b0;
        trefi = 28'd100;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        do_reset();
        active = 1'b1;
        cmp("rst_pending", int'(ref_pending), 0);
        repeat (1000) step();
        cmp("idle_autoref", int'(autoref_req), 0);
        cmp("idle_zq", int'(zq_req), 0);
        cmp("idle_pr", int'(pr_rd_req), 0);

        ref_en = 1'b1;
        for (int k = 1; k <= MAXP; k++) begin
            wait_inc(n);
            cmp($sformatf("ref_rise%0d", k), n, (k == 1) ? 101 : 100);
            cmp($sformatf("ref_cnt%0d", k), int'(ref_pending), k);
        end
        repeat (99) step();
        cmp("ovf_before", int'(ref_overflow), 0);
        step();
        cmp("ovf_after", int'(ref_overflow), 1);
        cmp("pend_sat", int'(ref_pending), MAXP);

        #2 rst_n = 1'b0;
        #1;
        cmp("async_pend", int'(ref_pending), 0);
        cmp("async_req", int'(autoref_req), 0);
        cmp("async_ovf", int'(ref_overflow), 0);
        ref_en = 1'b0;
        step();
        rst_n = 1'b1;

        ref_en = 1'b1;
        for (int k = 1; k <= TGT; k++) wait_inc(n);
        repeat (99) step();
        autoref_ack = 1'b1;
        step();
        autoref_ack = 1'b0;
        cmp("tick_ack_same", int'(ref_pending), TGT);
        for (int k = 0; k < TGT; k++) ack_pulse();
        cmp("ack_to_zero", int'(autoref_req), 0);
        ack_pulse();
        cmp("ack_at_zero", int'(ref_pending), 0);

        do_reset();
        ref_en = 1'b1;
        wait_inc(n);
        cmp("rt_first", n, 101);
        ack_pulse();
        repeat (29) step();
        trefi = 28'd40;
        wait_inc(n);
        cmp("rt_old_done", n, 70);
        ack_pulse();
        wait_inc(n);
        cmp("rt_new1", n, 39);
        ack_pulse();
        wait_inc(n);
        cmp("rt_new2", n, 39);
        ack_pulse();
        trefi = 28'd0;
        repeat (300) step();
        cmp("trefi0_pend", int'(ref_pending), 0);
        ref_en = 1'b0;
        trefi = 28'd100;

        zq_en = 1'b1;
        repeat (3) ack_pulse();
        cmp("zq_after3", int'(zq_req), 0);
        ack_pulse();
        cmp("zq_after4", int'(zq_req), 1);
        repeat (5) step();
        cmp("zq_hold", int'(zq_req), 1);
        zq_ack = 1'b1;
        step();
        zq_ack = 1'b0;
        cmp("zq_cleared", int'(zq_req), 0);
        zq_en = 1'b0;
        repeat (4) ack_pulse();
        cmp("zq_disabled", int'(zq_req), 0);
        zq_en = 1'b1;
        repeat (3) ack_pulse();
        autoref_ack = 1'b1;
        zq_ack = 1'b1;
        step();
        autoref_ack = 1'b0;
        zq_ack = 1'b0;
        cmp("zq_set_wins", int'(zq_req), 1);
        zq_ack = 1'b1;
        step();
        zq_ack = 1'b0;
        cmp("zq_clear2", int'(zq_req), 0);
        zq_en = 1'b0;

        pr_rd_en = 1'b1;
        wait_pr(n);
        cmp("pr_first", n, 16);
        periodic_read_lock = 1'b1;
        step();
        cmp("pr_lock_drop", int'(pr_rd_req), 0);
        repeat (49) step();
        cmp("pr_locked", int'(pr_rd_req), 0);
        periodic_read_lock = 1'b0;
        wait_pr(n);
        cmp("pr_after_lock", n, 16);
        pr_rd_en = 1'b0;
        step();
        cmp("pr_disabled", int'(pr_rd_req), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
